regfile_wb_arbiter: RTL and testbench

Write-back controller for the 32x32 integer register file. It shares the file's single write port among NUM_SRC write-back requesters (ALU, load unit, CSR unit) using valid/ready handshakes and round-robin arbitration. It drives the write port from a registered output stage and keeps a per-register pending-write scoreboard for decode hazard checks. It sits between the execute/memory stages and the register file write port.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 68 ++++++
 rtl/regfile_wb_arbiter.sv | 130 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and typedefs.
// Used by the write-back controller and by anything that talks to the 32x32 integer file.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  // Number of bits needed to index n items (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a one-hot combinational grant.
// The search starts at rr_ptr; rr_ptr moves past the winner when advance_in is set.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic [N-1:0] req_in,
  input  logic         advance_in,
  output logic [N-1:0] grant_out
);

  localparam int PTR_W = idx_width(N);

  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] rr_ptr_d;
  logic [PTR_W-1:0] gnt_idx_s;
  logic             gnt_found_s;
  logic [PTR_W:0]   idx_s;

  // Pick the first requester at or after rr_ptr, wrapping modulo N.
  always_comb begin
    grant_out   = '0;
    gnt_idx_s   = '0;
    gnt_found_s = 1'b0;
    idx_s       = '0;
    for (int k = 0; k < N; k++) begin
      idx_s = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (idx_s >= (PTR_W+1)'(N)) begin
        idx_s = idx_s - (PTR_W+1)'(N);
      end else begin
        idx_s = idx_s;
      end
      if (!gnt_found_s && req_in[idx_s[PTR_W-1:0]]) begin
        grant_out[idx_s[PTR_W-1:0]] = 1'b1;
        gnt_idx_s                   = idx_s[PTR_W-1:0];
        gnt_found_s                 = 1'b1;
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // Pointer moves to the requester after the winner.
  always_comb begin
    if (advance_in && gnt_found_s) begin
      if (gnt_idx_s == PTR_W'(N-1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx_s + PTR_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back controller: round-robin write-port sharing, registered
// write port and, when RF_SCOREBOARD_EN is defined, a per-register pending-write scoreboard.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = XLEN,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic [NUM_SRC-1:0]        src_valid_in,
  output logic [NUM_SRC-1:0]        src_ready_out,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr_in,
  input  logic [NUM_SRC*DATA_W-1:0] src_data_in,
  input  logic                      issue_valid_in,
  input  logic [ADDR_W-1:0]         issue_addr_in,
  output logic                      wr_en_out,
  output logic [ADDR_W-1:0]         rd_addr_out,
  output logic [DATA_W-1:0]         rd_out,
  output logic [2**ADDR_W-1:0]      busy_out
);

  localparam int NUM_R = 2**ADDR_W;

  logic [NUM_SRC-1:0] req_s;
  logic [NUM_SRC-1:0] grant_s;
  logic               grant_any_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [DATA_W-1:0]  sel_data_s;

  logic               wr_en_d;
  logic               wr_en_q;
  logic [ADDR_W-1:0]  rd_addr_d;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic [DATA_W-1:0]  rd_data_d;
  logic [DATA_W-1:0]  rd_data_q;

  // No grant may be issued while reset is asserted.
  assign req_s = src_valid_in & {NUM_SRC{rst_n_in}};

  rr_arbiter #(
    .N (NUM_SRC)
  ) u_arb (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .req_in     (req_s),
    .advance_in (grant_any_s),
    .grant_out  (grant_s)
  );

  assign grant_any_s   = |grant_s;
  assign src_ready_out = grant_s;

  // AND-OR mux of the granted requester; the grant is one-hot or zero.
  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_addr_s = sel_addr_s | (src_addr_in[i*ADDR_W +: ADDR_W] & {ADDR_W{grant_s[i]}});
      sel_data_s = sel_data_s | (src_data_in[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
    end
  end

  // Writes to x0 are accepted but dropped; idle port is forced to address 0 / data 0.
  always_comb begin
    wr_en_d = grant_any_s && (sel_addr_s != '0);
    if (wr_en_d) begin
      rd_addr_d = sel_addr_s;
      rd_data_d = sel_data_s;
    end else begin
      rd_addr_d = '0;
      rd_data_d = '0;
    end
  end

  // Registered write port.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign wr_en_out   = wr_en_q;
  assign rd_addr_out = rd_addr_q;
  assign rd_out      = rd_data_q;

`ifdef RF_SCOREBOARD_EN
  logic [NUM_R-1:0] busy_d;
  logic [NUM_R-1:0] busy_q;

  // Clear on write, then set on issue so a newer producer wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_d) begin
      busy_d[rd_addr_d] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (issue_valid_in && (issue_addr_in != '0)) begin
      busy_d[issue_addr_in] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Pending-write scoreboard.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_out = busy_q;
`else
  logic unused_issue_s;
  assign unused_issue_s = ^{issue_valid_in, issue_addr_in};
  assign busy_out       = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, hand sequences
// for scoreboard/reset corners, and randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

`ifdef RF_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      src_valid;
  logic [N-1:0]      src_ready;
  logic [N*AW-1:0]   src_addr;
  logic [N*DW-1:0]   src_data;
  logic              iv;
  logic [AW-1:0]     ia;
  logic              wr_en;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     rd;
  logic [NR-1:0]     busy;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_SRC(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .src_valid_in   (src_valid),
    .src_ready_out  (src_ready),
    .src_addr_in    (src_addr),
    .src_data_in    (src_data),
    .issue_valid_in (iv),
    .issue_addr_in  (ia),
    .wr_en_out      (wr_en),
    .rd_addr_out    (rd_addr),
    .rd_out         (rd),
    .busy_out       (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  int            m_ptr;
  bit [NR-1:0]   m_busy;
  bit            m_wr;
  int            m_addr;
  logic [DW-1:0] m_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_busy = '0;
    m_wr   = 1'b0;
    m_addr = 0;
    m_data = '0;
  endtask

  function automatic int model_grant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // One clock cycle: apply inputs, check the grant, step the model, check the registered outputs.
  task automatic cycle(input logic [N-1:0] v, input logic [N*AW-1:0] a, input logic [N*DW-1:0] d,
                       input logic iv_i, input logic [AW-1:0] ia_i, output int g);
    int ga;
    src_valid = v; src_addr = a; src_data = d; iv = iv_i; ia = ia_i;
    #1;
    g = model_grant(v);
    check("ready", 64'(src_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    @(posedge clk);
    if (g >= 0) begin
      ga     = int'(a[g*AW +: AW]);
      m_ptr  = (g + 1) % N;
      m_wr   = (ga != 0);
      m_addr = m_wr ? ga : 0;
      m_data = m_wr ? d[g*DW +: DW] : '0;
      if (SB && ga != 0) m_busy[ga] = 1'b0;
    end else begin
      m_wr = 1'b0; m_addr = 0; m_data = '0;
    end
    if (SB && iv_i && ia_i != '0) m_busy[ia_i] = 1'b1;
    #1;
    check("wr_en", 64'(wr_en), 64'(m_wr));
    check("rd_addr", 64'(rd_addr), 64'(m_addr));
    check("rd_data", 64'(rd), 64'(m_data));
    check("busy", 64'(busy), 64'(m_busy));
  endtask

  typedef struct {
    logic [N-1:0]    v;
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    logic [N-1:0]    exp_ready;
    logic            exp_wr;
    logic [AW-1:0]   exp_addr;
    logic [DW-1:0]   exp_data;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [N-1:0]  pv;
    logic [AW-1:0] pa [N];
    logic [DW-1:0] pd [N];
    logic [N*AW-1:0] ra;
    logic [N*DW-1:0] rdd;

    // Directed table, starting from rr_ptr = 0
    tbl[0] = '{3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF}, 3'b001, 1'b1, 5'd5, 32'hDEADBEEF};
    tbl[1] = '{3'b000, '0, '0, 3'b000, 1'b0, 5'd0, 32'h0};
    tbl[2] = '{3'b010, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h1234, 32'h0}, 3'b010, 1'b0, 5'd0, 32'h0};
    tbl[3] = '{3'b100, {5'd4, 5'd0, 5'd0}, {32'h44, 32'h0, 32'h0}, 3'b100, 1'b1, 5'd4, 32'h44};
    for (int i = 0; i < 6; i++) begin
      tbl[4+i].v         = 3'b111;
      tbl[4+i].a         = {5'd3, 5'd2, 5'd1};
      tbl[4+i].d         = {32'h300, 32'h200, 32'h100};
      tbl[4+i].exp_ready = 3'b001 << (i % 3);
      tbl[4+i].exp_wr    = 1'b1;
      tbl[4+i].exp_addr  = AW'((i % 3) + 1);
      tbl[4+i].exp_data  = DW'(((i % 3) + 1) * 256);
    end

    // Reset: outputs zero and no grant even with requests present
    rst_n = 1'b0; src_valid = 3'b111; src_addr = {5'd3, 5'd2, 5'd1}; src_data = '1; iv = 1'b1; ia = 5'd6;
    #2;
    check("rst_ready", 64'(src_ready), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_rd_data", 64'(rd), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 10; i++) begin
      logic [N-1:0] r_seen;
      src_valid = tbl[i].v; src_addr = tbl[i].a; src_data = tbl[i].d; iv = 1'b0; ia = '0;
      #1;
      r_seen = src_ready;
      cycle(tbl[i].v, tbl[i].a, tbl[i].d, 1'b0, '0, g);
      check("tbl_ready", 64'(r_seen), 64'(tbl[i].exp_ready));
      check("tbl_wr_en", 64'(wr_en), 64'(tbl[i].exp_wr));
      check("tbl_rd_addr", 64'(rd_addr), 64'(tbl[i].exp_addr));
      check("tbl_rd_data", 64'(rd), 64'(tbl[i].exp_data));
    end

    // Idle after traffic: port forced to zero
    cycle('0, '0, '0, 1'b0, '0, g);
    check("idle_rd_addr", 64'(rd_addr), 64'd0);

    // Issue x7, write x7 two cycles later from src2 (rr_ptr is 0 here)
    cycle('0, '0, '0, 1'b1, 5'd7, g);
    check("busy7_set", 64'(busy[7]), 64'(SB));
    cycle('0, '0, '0, 1'b0, '0, g);
    check("busy7_hold", 64'(busy[7]), 64'(SB));
    cycle(3'b100, {5'd7, 5'd0, 5'd0}, {32'h77, 32'h0, 32'h0}, 1'b0, '0, g);
    check("busy7_clr_wr", 64'(wr_en), 64'd1);
    check("busy7_clr", 64'(busy[7]), 64'd0);

    // Set and clear of x9 in the same cycle: set wins
    cycle('0, '0, '0, 1'b1, 5'd9, g);
    cycle(3'b001, {5'd0, 5'd0, 5'd9}, {32'h0, 32'h0, 32'h99}, 1'b1, 5'd9, g);
    check("busy9_setwins", 64'(busy[9]), 64'(SB));
    check("busy9_wr", 64'(rd_addr), 64'd9);

    // Reset mid-stream with x7/x9 busy and a write on the port
    cycle('0, '0, '0, 1'b1, 5'd7, g);
    cycle(3'b010, {5'd0, 5'd3, 5'd0}, {32'h0, 32'hABC, 32'h0}, 1'b0, '0, g);
    check("pre_rst_busy", 64'(busy), SB ? 64'h280 : 64'h0);
    check("pre_rst_wr", 64'(wr_en), 64'd1);
    src_valid = 3'b111; src_addr = {5'd3, 5'd2, 5'd1}; src_data = {32'h3, 32'h2, 32'h1};
    rst_n = 1'b0;
    #1;
    check("arst_wr_en", 64'(wr_en), 64'd0);
    check("arst_rd_addr", 64'(rd_addr), 64'd0);
    check("arst_rd_data", 64'(rd), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_ready", 64'(src_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1}, 1'b0, '0, g);
    check("post_rst_first_grant", 64'(g), 64'd0);

    // Randomized traffic; each requester holds its request until accepted
    pv = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && ($urandom_range(0, 1) == 1)) begin
          pv[i] = 1'b1;
          pa[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(0, NR-1));
          pd[i] = $urandom;
        end
      end
      for (int i = 0; i < N; i++) begin
        ra[i*AW +: AW]  = pv[i] ? pa[i] : '0;
        rdd[i*DW +: DW] = pv[i] ? pd[i] : '0;
      end
      cycle(pv, ra, rdd, ($urandom_range(0, 2) == 0), AW'($urandom_range(0, NR-1)), g);
      if (g >= 0) pv[g] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
